// File: rtl/lsu_ctrl.sv
// Load/store sequencing controller: one request at a time, word-aligned memory
// accesses (misaligned half/word split in two), lane merge and load extension.
module lsu_ctrl (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsign,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_mem_req,
  input  logic        i_mem_ack,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_bmask,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic [1:0]  o_dbg_state
);

  // Handshakes: a request transfers on the edge where i_req_valid & o_req_ready;
  // a memory access completes on the edge where o_mem_req & i_mem_ack, and the
  // request outputs are held unchanged until then. o_rsp_valid has no ready.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC0 = 2'd1,
    S_ACC1 = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      state;
  logic        req_we;
  logic        req_unsign;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata0;
  logic [31:0] result;

  logic [3:0]  size_mask;
  logic [7:0]  lane_map;
  logic        split;
  logic [4:0]  lane_shift;
  logic [31:0] word_addr;

  // Lanes touched across two consecutive words: low nibble is the first
  // access, high nibble (if any) spills into the next word.
  always_comb begin
    size_mask = 4'b1111;
    case (req_size)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    lane_map   = {4'b0000, size_mask} << req_addr[1:0];
    split      = |lane_map[7:4];
    lane_shift = {req_addr[1:0], 3'b000};
    word_addr  = {req_addr[31:2], 2'b00};
  end

  function automatic logic [31:0] load_fmt(input logic [31:0] lo, input logic [31:0] hi,
                                           input logic [1:0] off, input logic [1:0] size,
                                           input logic uns);
    logic [63:0] both;
    logic [31:0] raw;
    both = {hi, lo} >> {off, 3'b000};
    raw  = both[31:0];
    case (size)
      2'b00:   return uns ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   return uns ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= S_IDLE;
      req_we     <= 1'b0;
      req_unsign <= 1'b0;
      req_size   <= 2'b00;
      req_addr   <= 32'h0;
      req_wdata  <= 32'h0;
      rdata0     <= 32'h0;
      result     <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_req_valid) begin
            req_we     <= i_req_we;
            req_unsign <= i_req_unsign;
            req_size   <= i_req_size;
            req_addr   <= i_req_addr;
            req_wdata  <= i_req_wdata;
            state      <= S_ACC0;
          end
        end
        S_ACC0: begin
          if (i_mem_ack) begin
            if (split) begin
              rdata0 <= i_mem_rdata;
              state  <= S_ACC1;
            end else begin
              result <= req_we ? 32'h0
                      : load_fmt(i_mem_rdata, 32'h0, req_addr[1:0], req_size, req_unsign);
              state  <= S_RESP;
            end
          end
        end
        S_ACC1: begin
          if (i_mem_ack) begin
            result <= req_we ? 32'h0
                    : load_fmt(rdata0, i_mem_rdata, req_addr[1:0], req_size, req_unsign);
            state  <= S_RESP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from state and forced quiet while reset is asserted,
  // so an access in flight is dropped in the reset cycle itself.
  always_comb begin
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_rsp_rdata = 32'h0;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = 32'h0;
    o_mem_bmask = 4'h0;
    o_mem_wdata = 32'h0;
    if (!i_reset) begin
      case (state)
        S_IDLE: o_req_ready = 1'b1;
        S_ACC0: begin
          o_mem_req   = 1'b1;
          o_mem_we    = req_we;
          o_mem_addr  = word_addr;
          o_mem_bmask = lane_map[3:0];
          o_mem_wdata = req_wdata << lane_shift;
        end
        S_ACC1: begin
          o_mem_req   = 1'b1;
          o_mem_we    = req_we;
          o_mem_addr  = word_addr + 32'd4;
          o_mem_bmask = lane_map[7:4];
          o_mem_wdata = req_wdata >> (6'd32 - {1'b0, lane_shift});
        end
        default: begin
          o_rsp_valid = 1'b1;
          o_rsp_rdata = result;
        end
      endcase
    end
  end

  assign o_dbg_state = state;

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencing controller between the execute stage and the data memory port. It accepts one load or store request at a time and generates the word-aligned address, byte-lane mask and lane-shifted store data. It splits misaligned half/word accesses into two word accesses and waits on a variable-latency memory acknowledge. It merges and shifts the returned lanes, then applies byte/halfword sign or zero extension (the same rules as the load-formatting stage) before returning one response.

## Interface
- No parameters; data and address width fixed at 32.
- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  controller can accept a request
- i_req_we  in  1  1 = store, 0 = load
- i_req_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
- i_req_unsign  in  1  load zero-extends when 1, sign-extends when 0
- i_req_addr  in  32  byte address
- i_req_wdata  in  32  store data, right-justified
- o_rsp_valid  out  1  one-cycle completion pulse (loads and stores)
- o_rsp_rdata  out  32  extended load result; 0 for stores
- o_mem_req  out  1  memory access request
- i_mem_ack  in  1  memory access complete
- o_mem_we  out  1  write enable
- o_mem_addr  out  32  word-aligned address, bits [1:0] = 00
- o_mem_bmask  out  4  byte-lane enables, bit n = byte lane n
- o_mem_wdata  out  32  lane-aligned store data
- i_mem_rdata  in  32  read word, valid in the cycle i_mem_ack is high

## Operation
- The FSM has four states: IDLE, ACC0, ACC1 and RESP.
- **Request capture.**
  - In IDLE, o_req_ready = 1.
  - On i_req_valid & o_req_ready, the controller latches we/size/unsign/addr/wdata and moves to ACC0.
  - Offset off = addr[1:0]. Byte count n = 1/2/4 by size.
- **Split rule.** An access is misaligned when off + n > 4. Only halfword at off = 3 and word at off ≠ 0 are misaligned; a byte access is never misaligned.
- **ACC0.**
  - o_mem_addr = {addr[31:2], 2'b00}.
  - o_mem_bmask = lanes off .. min(off+n, 4) − 1.
  - o_mem_wdata = wdata << 8·off.
  - On ack: if misaligned, capture rdata and go to ACC1; otherwise go to RESP.
- **ACC1.**
  - o_mem_addr = ACC0 address + 4, mod 2^32 (0xFFFFFFFC wraps to 0x00000000).
  - o_mem_bmask = lanes 0 .. off+n−5.
  - o_mem_wdata = wdata >> 8·(4−off).
  - On ack, go to RESP.
- **Load merge.**
  - raw = (rdata0 >> 8·off) | (rdata1 << 8·(4−off)); the second term applies only when the access was split.
  - Byte: result = raw[7:0], extended from bit 7.
  - Halfword: result = raw[15:0], extended from bit 15.
  - Word: result = raw unchanged; i_req_unsign is ignored.
  - Extension fills with zeros when unsign = 1 and with copies of the sign bit otherwise.
- **RESP.** o_rsp_valid = 1 for exactly one cycle, then the FSM returns to IDLE. There is no response back-pressure.
- o_mem_we equals the latched we in ACC0/ACC1 and is 0 otherwise. o_mem_bmask and o_mem_wdata are 0 outside ACC0/ACC1.

## Timing
- **Reset.** Synchronous: on the edge where i_reset is high, state becomes IDLE and captured data is cleared. Outputs while i_reset is high:
  - o_req_ready = 0
  - o_mem_req = 0, o_mem_we = 0
  - o_rsp_valid = 0, o_rsp_rdata = 0
  - o_mem_addr = 0, o_mem_bmask = 0, o_mem_wdata = 0
- The first cycle after i_reset deasserts has o_req_ready = 1.
- **Memory handshake.**
  - o_mem_req is high in every ACC0/ACC1 cycle.
  - Address, mask, data and we stay stable until the edge where i_mem_ack = 1 is sampled.
  - Ack may arrive in the first request cycle (zero wait).
  - i_mem_ack while o_mem_req = 0 is ignored.
  - Between ACC0 and ACC1, o_mem_req stays high; only the address, mask and data change.
- **Latency**, from the accept edge to the o_rsp_valid cycle: 2 cycles for an aligned access with zero-wait ack, 3 for a split access with zero-wait ack, plus one cycle per wait cycle.
- **Throughput.** o_req_ready is 0 from the accept edge through RESP, so a new request is accepted no earlier than the IDLE cycle after RESP.
- **Reset mid-access.** The access aborts: o_mem_req is 0 from the reset cycle, no o_rsp_valid is produced, and a pending ack is discarded.

## Test plan
- **Aligned signed byte load.** lb with addr 0x103, i_mem_rdata = 0xF4000000, zero-wait ack → o_mem_addr 0x100, bmask 1000; o_rsp_rdata 0xFFFFFFF4 two cycles after accept. Repeat as lbu → 0x000000F4.
- **Misaligned word load.** lw with addr 0x102; word 0x100 = 0xAABBCCDD, word 0x104 = 0x11223344 → accesses 0x100/bmask 1100, then 0x104/bmask 0011; o_rsp_rdata = 0x3344AABB, three cycles after accept.
- **Misaligned halfword load.** lh with addr 0x103; word 0x100 = 0x80000000, word 0x104 = 0x000000FF → 0xFFFFFF80. The same access as lhu → 0x0000FF80.
- **Misaligned word store.** sw with data 0x12345678, addr 0x101 → access 1: addr 0x100, bmask 1110, wdata 0x34567800, we 1; access 2: addr 0x104, bmask 0001, wdata 0x00000012; then o_rsp_valid with rdata 0.
- **Wait states, wrap and stability.** lw with addr 0xFFFFFFFE and 3 wait cycles per access → request outputs held stable while waiting; second address 0x00000000; o_req_ready stays 0 throughout and i_req_valid is ignored.
- **Reset mid-access.** Assert i_reset during ACC1 of a split load → o_mem_req drops in that cycle, no o_rsp_valid, o_req_ready = 1 in the cycle after reset release, and a following aligned lw completes normally.
